// File: rtl/timer_counter_pkg.sv
// Shared constants for the memory-mapped timer: register offsets, CTRL field positions,
// mode encodings and FSM state encodings.
package timer_counter_pkg;

  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegPreset = 2'd1;
  localparam logic [1:0] RegCount  = 2'd2;

  localparam int unsigned CtrlEn     = 0;
  localparam int unsigned CtrlModeLo = 1;
  localparam int unsigned CtrlModeHi = 2;
  localparam int unsigned CtrlIm     = 3;

  localparam logic [1:0] ModeReload = 2'd1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StCnt  = 2'd2;
  localparam logic [1:0] StInt  = 2'd3;

  // Encodings 2 and 3 fall back to one-shot.
  function automatic logic isReload(input logic [1:0] mode);
    return mode == ModeReload;
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// CPU-side data bus of the timer: word access decoded on addr[3:2], plus the level irq to CP0.
interface timer_counter_if #(
  parameter int unsigned WIDTH = 32
);
  logic [31:0]      addr;
  logic             we;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd;
  logic             irq;

  modport master (output addr, we, wd, input rd, irq);
  modport slave  (input addr, we, wd, output rd, irq);
endinterface

// File: rtl/timer_counter.sv
// Down-counting timer with CTRL/PRESET/COUNT registers, one-shot or auto-reload modes and
// a maskable interrupt flag.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CTRL_BITS = 4
) (
  input  logic           clk,
  input  logic           reset,
  timer_counter_if.slave bus
);

  logic [CTRL_BITS-1:0] ctrlQ, ctrlD;
  logic [WIDTH-1:0]     presetQ, presetD;
  logic [WIDTH-1:0]     countQ, countD;
  logic [1:0]           stateQ, stateD;
  logic                 irqFlagQ, irqFlagD;
  logic                 irqSet;

  logic [1:0] regSel;
  logic       ctrlWrite;
  logic       presetWrite;
  logic       enable;
  logic       reload;
  logic       unusedAddr;

  assign regSel      = bus.addr[3:2];
  assign unusedAddr  = ^{bus.addr[31:4], bus.addr[1:0]};
  assign ctrlWrite   = bus.we && (regSel == RegCtrl);
  assign presetWrite = bus.we && (regSel == RegPreset);
  assign enable      = ctrlQ[CtrlEn];
  assign reload      = isReload(ctrlQ[CtrlModeHi:CtrlModeLo]);

  always_comb begin
    stateD   = stateQ;
    countD   = countQ;
    ctrlD    = ctrlQ;
    presetD  = presetQ;
    irqFlagD = irqFlagQ;
    irqSet   = 1'b0;

    case (stateQ)
      StIdle: if (enable) stateD = StLoad;
      StLoad: begin
        countD = presetQ;
        stateD = StCnt;
      end
      StCnt: begin
        if (!enable) begin
          stateD = StIdle;
        end else if (countQ == '0) begin
          stateD = StInt;
          irqSet = 1'b1;
        end else begin
          countD = countQ - WIDTH'(1);
        end
      end
      StInt: begin
        if (reload) begin
          stateD   = StLoad;
          irqFlagD = 1'b0;
        end else begin
          stateD        = StIdle;
          ctrlD[CtrlEn] = 1'b0;
        end
      end
      default: stateD = StIdle;
    endcase

    // A CPU write to CTRL overrides the FSM's En clear; a same-edge flag set beats the clear.
    if (ctrlWrite) begin
      ctrlD    = bus.wd[CTRL_BITS-1:0];
      irqFlagD = 1'b0;
    end
    if (presetWrite) presetD = bus.wd;
    if (irqSet) irqFlagD = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrlQ    <= '0;
      presetQ  <= '0;
      countQ   <= '0;
      stateQ   <= StIdle;
      irqFlagQ <= 1'b0;
    end else begin
      ctrlQ    <= ctrlD;
      presetQ  <= presetD;
      countQ   <= countD;
      stateQ   <= stateD;
      irqFlagQ <= irqFlagD;
    end
  end

  always_comb begin
    case (regSel)
      RegCtrl:   bus.rd = WIDTH'(ctrlQ);
      RegPreset: bus.rd = presetQ;
      RegCount:  bus.rd = countQ;
      default:   bus.rd = '0;
    endcase
  end

  assign bus.irq = irqFlagQ & ctrlQ[CtrlIm];

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: a vector table for register access and one-shot timing,
// then hand-written sequences for reload, disable, masking, write/FSM races and reset.
module tb_timer_counter;

  localparam logic [31:0] ACtrl   = 32'h0;
  localparam logic [31:0] APreset = 32'h4;
  localparam logic [31:0] ACount  = 32'h8;
  localparam logic [31:0] ARsv    = 32'hC;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] expRd;
    logic        expIrq;
  } vecT;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vecT  vecs[26];

  timer_counter_if #(.WIDTH(32)) bus ();

  timer_counter #(
    .WIDTH(32),
    .CTRL_BITS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a;
    bus.wd   = d;
    bus.we   = 1'b1;
    tick();
    bus.we   = 1'b0;
  endtask

  task automatic rdChk(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    check(name, bus.rd, exp);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    bus.addr = '0;
    bus.we   = 1'b0;
    bus.wd   = '0;

    // Each vector is checked just before the edge it is clocked on. The CTRL write of
    // vector 5 is edge t0; the irq flag lands at t0+PRESET+3.
    vecs[0]  = '{ACtrl,   1'b0, 32'h0,        32'h0, 1'b0};
    vecs[1]  = '{APreset, 1'b0, 32'h0,        32'h0, 1'b0};
    vecs[2]  = '{ACount,  1'b0, 32'h0,        32'h0, 1'b0};
    vecs[3]  = '{ARsv,    1'b0, 32'h0,        32'h0, 1'b0};
    vecs[4]  = '{APreset, 1'b1, 32'h5,        32'h0, 1'b0};
    vecs[5]  = '{ACtrl,   1'b1, 32'h9,        32'h0, 1'b0};
    vecs[6]  = '{ACount,  1'b0, 32'h0,        32'h0, 1'b0};
    vecs[7]  = '{ACount,  1'b0, 32'h0,        32'h0, 1'b0};
    vecs[8]  = '{ACount,  1'b0, 32'h0,        32'h5, 1'b0};
    vecs[9]  = '{ACount,  1'b0, 32'h0,        32'h4, 1'b0};
    vecs[10] = '{ACount,  1'b0, 32'h0,        32'h3, 1'b0};
    vecs[11] = '{ACount,  1'b0, 32'h0,        32'h2, 1'b0};
    vecs[12] = '{ACount,  1'b0, 32'h0,        32'h1, 1'b0};
    vecs[13] = '{ACount,  1'b0, 32'h0,        32'h0, 1'b0};
    vecs[14] = '{ACount,  1'b0, 32'h0,        32'h0, 1'b1};
    vecs[15] = '{ACtrl,   1'b0, 32'h0,        32'h8, 1'b1};
    vecs[16] = '{ACount,  1'b0, 32'h0,        32'h0, 1'b1};
    vecs[17] = '{ACtrl,   1'b1, 32'h0,        32'h8, 1'b1};
    vecs[18] = '{ACtrl,   1'b0, 32'h0,        32'h0, 1'b0};
    vecs[19] = '{ACount,  1'b1, 32'h77,       32'h0, 1'b0};
    vecs[20] = '{ACount,  1'b0, 32'h0,        32'h0, 1'b0};
    vecs[21] = '{ARsv,    1'b1, 32'hFF,       32'h0, 1'b0};
    vecs[22] = '{ARsv,    1'b0, 32'h0,        32'h0, 1'b0};
    vecs[23] = '{ACtrl,   1'b1, 32'hFFFFFFF8, 32'h0, 1'b0};
    vecs[24] = '{ACtrl,   1'b0, 32'h0,        32'h8, 1'b0};
    vecs[25] = '{ACtrl,   1'b1, 32'h0,        32'h8, 1'b0};

    repeat (2) tick();
    reset = 1'b0;

    for (int i = 0; i < 26; i++) begin
      bus.addr = vecs[i].addr;
      bus.we   = vecs[i].we;
      bus.wd   = vecs[i].wd;
      #1;
      check($sformatf("vec%0d rd", i), bus.rd, vecs[i].expRd);
      check($sformatf("vec%0d irq", i), bus.irq, vecs[i].expIrq);
      tick();
    end
    bus.we = 1'b0;

    // Auto-reload, PRESET=3: period of 6 edges with irq high only in INT.
    wr(APreset, 32'd3);
    wr(ACtrl, 32'hB);
    bus.addr = ACount;
    for (int c = 1; c <= 18; c++) begin
      int m;
      tick();
      m = c % 6;
      check($sformatf("reload irq c%0d", c), bus.irq, (m == 0));
      check($sformatf("reload count c%0d", c), bus.rd, (m >= 2) ? 5 - m : 0);
    end
    wr(ACtrl, 32'h0);
    repeat (3) tick();

    // Disable mid-count: COUNT freezes, no irq; re-enable reloads from PRESET.
    wr(APreset, 32'd6);
    wr(ACtrl, 32'h9);
    repeat (5) tick();
    rdChk("pause pre", ACount, 32'd3);
    wr(ACtrl, 32'h8);
    rdChk("pause edge", ACount, 32'd2);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("pause hold", bus.rd, 32'd2);
      check("pause irq", bus.irq, 1'b0);
    end
    wr(ACtrl, 32'h9);
    repeat (2) tick();
    rdChk("resume reload", ACount, 32'd6);
    wr(ACtrl, 32'h0);
    tick();

    // IM=0 masks expiry; a later CTRL write clears the retained flag.
    wr(APreset, 32'd1);
    wr(ACtrl, 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("masked irq", bus.irq, 1'b0);
    end
    rdChk("masked ctrl en cleared", ACtrl, 32'h0);
    wr(ACtrl, 32'h8);
    check("unmask after clear", bus.irq, 1'b0);
    rdChk("unmask ctrl", ACtrl, 32'h8);
    tick();
    check("unmask irq later", bus.irq, 1'b0);
    wr(ACtrl, 32'h0);

    // PRESET=0 expires at t0+3; CPU write in INT beats the En clear; flag set beats write clear.
    wr(APreset, 32'd0);
    wr(ACtrl, 32'h9);
    repeat (2) tick();
    check("p0 before", bus.irq, 1'b0);
    tick();
    check("p0 irq at t3", bus.irq, 1'b1);
    wr(ACtrl, 32'h9);
    check("cpu wins irq cleared", bus.irq, 1'b0);
    rdChk("cpu wins ctrl", ACtrl, 32'h9);
    repeat (2) tick();
    check("race pre irq", bus.irq, 1'b0);
    wr(ACtrl, 32'h9);
    check("set wins irq", bus.irq, 1'b1);
    tick();
    rdChk("race int ctrl", ACtrl, 32'h8);
    check("race int irq held", bus.irq, 1'b1);
    wr(ACtrl, 32'h0);

    // Reset mid-count aborts everything.
    wr(APreset, 32'd10);
    wr(ACtrl, 32'h9);
    bus.addr = ACount;
    repeat (5) tick();
    check("pre-reset count", bus.rd, 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rdChk("rst ctrl", ACtrl, 32'h0);
    rdChk("rst preset", APreset, 32'h0);
    rdChk("rst count", ACount, 32'h0);
    check("rst irq", bus.irq, 1'b0);
    repeat (3) tick();
    check("rst idle count", bus.rd, 32'h0);
    check("rst idle irq", bus.irq, 1'b0);

    // PRESET rewritten during CNT: the running countdown keeps the old value.
    wr(APreset, 32'd3);
    wr(ACtrl, 32'h9);
    repeat (2) tick();
    rdChk("old preset load", ACount, 32'd3);
    wr(APreset, 32'd10);
    rdChk("old preset dec", ACount, 32'd2);
    repeat (3) tick();
    check("old preset expire irq", bus.irq, 1'b1);
    check("old preset expire count", bus.rd, 32'd0);
    tick();
    rdChk("new preset stored", APreset, 32'd10);
    wr(ACtrl, 32'h9);
    repeat (2) tick();
    rdChk("new preset load", ACount, 32'd10);
    wr(ACtrl, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
